tod_counter: RTL and testbench
==============================

TOD_COUNTER -- requirements
Module: tod_counter

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000: clk cycles per second; legal range is 2 or more.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port run, input, 1 bit: 1 = time advances, 0 = time frozen.
REQ-005 SHALL have port set_time, input, 1 bit: load request for bin_time.
REQ-006 SHALL have port bin_time, input, 17 bits: packed as {hour[4:0], min[5:0], sec[5:0]}, binary.
REQ-007 SHALL have port alarm_on, input, 1 bit: alarm arm enable.
REQ-008 SHALL have port alarm_time, input, 11 bits: packed as {hour[4:0], min[5:0]}.
REQ-009 SHALL have port alarm_ack, input, 1 bit: silences a ringing alarm.
REQ-010 SHALL have outputs hour [4:0], min [5:0] and sec [5:0]: current time, registered.
REQ-011 SHALL have output en_day, 1 bit: one-cycle day-advance pulse for the downstream date stage.
REQ-012 SHALL have output tick, 1 bit: one-cycle 1 Hz strobe.
REQ-013 SHALL have output alarm, 1 bit: alarm ringing.

Function
REQ-014 SHALL generate tick with a prescaler counting 0..CLK_HZ-1 while run=1; tick=1 for exactly one cycle when count equals CLK_HZ-1, after which count returns to 0.
REQ-015 SHALL hold the prescaler count and suppress tick while run=0; counting resumes from the held count when run returns to 1.
REQ-016 SHALL, on tick, increment sec; sec 59 wraps to 0 and carries into min; min 59 wraps to 0 and carries into hour; hour 23 wraps to 0.
REQ-017 SHALL assert en_day for exactly one cycle, in the same cycle that the outputs first read 00:00:00 after a 23:59:59 rollover.
REQ-018 SHALL, on set_time=1, load bin_time only if hour<=23, min<=59 and sec<=59; an invalid value is ignored and the time is unchanged.
REQ-019 SHALL clear the prescaler on any accepted load, so the first tick after a load arrives CLK_HZ cycles later.
REQ-020 SHALL give set_time priority over a same-cycle tick: the loaded value is used, there is no increment, and en_day stays 0 even when loading 00:00:00.
REQ-021 SHALL run the alarm FSM with states IDLE and RING; reset state is IDLE.
REQ-022 SHALL move IDLE->RING on a tick-driven update to {alarm_time, sec=0} while alarm_on=1; a time load never triggers the alarm.
REQ-023 SHALL move RING->IDLE on alarm_ack=1, on alarm_on=0, or after the 60th tick spent in RING, whichever comes first.
REQ-024 SHALL drive alarm=1 exactly while the FSM is in RING; alarm is registered.

Reset
REQ-025 SHALL, while rst=0, force hour=0, min=0, sec=0, en_day=0, tick=0, alarm=0, prescaler=0, FSM=IDLE and ring counter=0, regardless of any other input.
REQ-026 SHALL resume normal operation on the first rising clk edge after rst deasserts; a reset that occurs mid-ring discards the alarm.

Configuration
REQ-027 SHALL, when macro TOD_ALARM_EN is defined, implement the alarm function of REQ-021 to REQ-024.
REQ-028 SHALL, when TOD_ALARM_EN is undefined, keep all alarm ports, tie alarm to 0, ignore alarm_on, alarm_time and alarm_ack, and synthesize no alarm logic.

Structure
REQ-029 SHALL take from shared package clock_pkg: constants MAX_HOUR=23, MAX_MIN=59, MAX_SEC=59, the field widths (5/6/6) and the alarm state enum.
REQ-030 SHALL place the prescaler in sub-module tick_gen (ports clk, rst, run, clr; parameter CLK_HZ; output tick); all other logic stays in tod_counter.

Verification (CLK_HZ=4)
REQ-031 SHALL verify: hold rst=0, then release -> 00:00:00, en_day=0, alarm=0, and the first tick arrives 4 cycles after release with run=1.
REQ-032 SHALL verify: load 23:59:58, run=1 -> 23:59:59 after 4 cycles, then 00:00:00 with en_day high for exactly one cycle.
REQ-033 SHALL verify: load 24:00:00, then 12:60:00 -> the time is unchanged at its prior value both times.
REQ-034 SHALL verify: set_time in the same cycle as tick, loading 10:20:30 -> reads 10:20:30, the next tick occurs 4 cycles later, and en_day stays 0.
REQ-035 SHALL verify: run=0 for 20 cycles -> time and prescaler frozen and no tick; after run=1 counting resumes from the held count.
REQ-036 SHALL verify, with TOD_ALARM_EN defined and alarm_time=07:30, alarm_on=1, load 07:29:59: alarm=1 at 07:30:00; alarm_ack clears it the next cycle; with no ack it clears at 07:31:00.

Source files
------------

// File: rtl/clock_pkg.sv
// clock_pkg: shared time-field widths, limits, alarm state encoding and a load-validity helper. Rev 1.0
`default_nettype none

package clock_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;
  localparam int TIME_W = HOUR_W + MIN_W + SEC_W;
  localparam int HM_W   = HOUR_W + MIN_W;

  localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
  localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;
  localparam logic [SEC_W-1:0]  MAX_SEC  = 6'd59;

  // Last count value of the ring counter: the alarm rings for 60 ticks at most.
  localparam logic [5:0] RING_LAST = 6'd59;

  typedef enum logic [0:0] {
    ALARM_IDLE = 1'b0,
    ALARM_RING = 1'b1
  } alarm_state_t;

  function automatic logic time_valid(input logic [HOUR_W-1:0] h,
                                      input logic [MIN_W-1:0]  m,
                                      input logic [SEC_W-1:0]  s);
    return (h <= MAX_HOUR) && (m <= MAX_MIN) && (s <= MAX_SEC);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// tick_gen: 1 Hz prescaler counting 0..CLK_HZ-1 while run=1; clr restarts the count. Rev 1.0
`default_nettype none

module tick_gen #(
  parameter int CLK_HZ = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(CLK_HZ);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = run & (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tod_counter.sv
// tod_counter: settable hh:mm:ss counter with day-advance pulse; alarm FSM built only with TOD_ALARM_EN. Rev 1.0
`default_nettype none

module tod_counter
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        set_time,
  input  logic [16:0] bin_time,
  input  logic        alarm_on,
  input  logic [10:0] alarm_time,
  input  logic        alarm_ack,
  output logic [4:0]  hour,
  output logic [5:0]  min,
  output logic [5:0]  sec,
  output logic        en_day,
  output logic        tick,
  output logic        alarm
);

  logic [HOUR_W-1:0] hour_q, hour_d;
  logic [MIN_W-1:0]  min_q,  min_d;
  logic [SEC_W-1:0]  sec_q,  sec_d;
  logic              en_day_q, en_day_d;
  logic              load_ok;
  logic              tick_upd;

  assign load_ok = set_time && time_valid(bin_time[16:12], bin_time[11:6], bin_time[5:0]);

  tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .clr  (load_ok),
    .tick (tick)
  );

  // A valid load wins over a same-cycle tick and never raises en_day.
  always_comb begin
    hour_d   = hour_q;
    min_d    = min_q;
    sec_d    = sec_q;
    en_day_d = 1'b0;
    tick_upd = 1'b0;
    if (load_ok) begin
      hour_d = bin_time[16:12];
      min_d  = bin_time[11:6];
      sec_d  = bin_time[5:0];
    end else if (tick) begin
      tick_upd = 1'b1;
      if (sec_q == MAX_SEC) begin
        sec_d = '0;
        if (min_q == MAX_MIN) begin
          min_d = '0;
          if (hour_q == MAX_HOUR) begin
            hour_d   = '0;
            en_day_d = 1'b1;
          end else begin
            hour_d = hour_q + 5'd1;
          end
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hour_q   <= '0;
      min_q    <= '0;
      sec_q    <= '0;
      en_day_q <= 1'b0;
    end else begin
      hour_q   <= hour_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      en_day_q <= en_day_d;
    end
  end

  assign hour   = hour_q;
  assign min    = min_q;
  assign sec    = sec_q;
  assign en_day = en_day_q;

`ifdef TOD_ALARM_EN
  alarm_state_t state_q;
  logic [5:0]   ring_cnt_q;
  logic         alarm_q;
  logic         alarm_hit;

  // Only a counting update can land on the alarm minute; loads never trigger it.
  assign alarm_hit = tick_upd && alarm_on && ({hour_d, min_d} == alarm_time) && (sec_d == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ALARM_IDLE;
      ring_cnt_q <= '0;
      alarm_q    <= 1'b0;
    end else if (state_q == ALARM_IDLE) begin
      if (alarm_hit) begin
        state_q    <= ALARM_RING;
        ring_cnt_q <= '0;
        alarm_q    <= 1'b1;
      end
    end else begin
      if (alarm_ack || !alarm_on || (tick && ring_cnt_q == RING_LAST)) begin
        state_q    <= ALARM_IDLE;
        ring_cnt_q <= '0;
        alarm_q    <= 1'b0;
      end else if (tick) begin
        ring_cnt_q <= ring_cnt_q + 6'd1;
      end
    end
  end

  assign alarm = alarm_q;
`else
  logic unused_alarm;
  assign unused_alarm = ^{alarm_on, alarm_time, alarm_ack, tick_upd};
  assign alarm = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tod_counter.sv
// tb_tod_counter: table-driven loads plus scoreboard-checked sequences for tod_counter at CLK_HZ=4.
`default_nettype none

module tb_tod_counter;

  localparam int HZ = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        set_time = 1'b0;
  logic [16:0] bin_time = '0;
  logic        alarm_on = 1'b0;
  logic [10:0] alarm_time = '0;
  logic        alarm_ack = 1'b0;
  logic [4:0]  hour;
  logic [5:0]  min;
  logic [5:0]  sec;
  logic        en_day;
  logic        tick;
  logic        alarm;

  tod_counter #(.CLK_HZ(HZ)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .set_time   (set_time),
    .bin_time   (bin_time),
    .alarm_on   (alarm_on),
    .alarm_time (alarm_time),
    .alarm_ack  (alarm_ack),
    .hour       (hour),
    .min        (min),
    .sec        (sec),
    .en_day     (en_day),
    .tick       (tick),
    .alarm      (alarm)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: time kept as seconds-of-day.
  int m_cnt = 0;
  int m_tod = 0;
  bit m_en = 1'b0;
  bit m_ring = 1'b0;
  int m_ring_ticks = 0;

  typedef struct packed {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic       en;
    logic       al;
  } obs_t;

  obs_t exp_q[$];

  typedef struct {
    logic [16:0] bin;
    logic [16:0] exp_time;
  } load_vec_t;

  function automatic logic [16:0] pk(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.h  = 5'(m_tod / 3600);
    o.m  = 6'((m_tod / 60) % 60);
    o.s  = 6'(m_tod % 60);
    o.en = m_en;
    o.al = m_ring;
    return o;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: check tick, advance the model, push expectation, compare after the edge.
  task automatic step(input string name);
    bit   mtick;
    bit   load;
    obs_t e;
    obs_t a;
    #1;
    if (!rst) begin
      m_cnt = 0; m_tod = 0; m_en = 0; m_ring = 0; m_ring_ticks = 0;
    end
    mtick = rst && run && (m_cnt == HZ - 1);
    checks++;
    if (tick !== mtick) begin
      errors++;
      $display("FAIL %s tick: got %b, expected %b", name, tick, mtick);
    end
    if (rst) begin
      load = set_time && (bin_time[16:12] < 24) && (bin_time[11:6] < 60) && (bin_time[5:0] < 60);
      m_en = 1'b0;
      if (load) begin
        m_tod = int'(bin_time[16:12]) * 3600 + int'(bin_time[11:6]) * 60 + int'(bin_time[5:0]);
        m_cnt = 0;
      end else begin
        if (run) m_cnt = mtick ? 0 : m_cnt + 1;
        if (mtick) begin
          m_tod = (m_tod + 1) % 86400;
          m_en  = (m_tod == 0);
        end
      end
`ifdef TOD_ALARM_EN
      if (m_ring) begin
        if (alarm_ack || !alarm_on) begin
          m_ring = 1'b0;
        end else if (mtick) begin
          m_ring_ticks++;
          if (m_ring_ticks == 60) m_ring = 1'b0;
        end
      end else if (mtick && !load && alarm_on &&
                   m_tod == int'(alarm_time[10:6]) * 3600 + int'(alarm_time[5:0]) * 60) begin
        m_ring = 1'b1;
        m_ring_ticks = 0;
      end
`endif
    end
    exp_q.push_back(model_obs());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    a = {hour, min, sec, en_day, alarm};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s outputs: got %0d:%0d:%0d en_day=%b alarm=%b, expected %0d:%0d:%0d en_day=%b alarm=%b",
               name, a.h, a.m, a.s, a.en, a.al, e.h, e.m, e.s, e.en, e.al);
    end
  endtask

  task automatic load(input logic [16:0] t);
    set_time = 1'b1;
    bin_time = t;
    step("load");
    set_time = 1'b0;
  endtask

  task automatic run_until_alarm(input logic level, input int limit, input string name);
    int n = 0;
    while (alarm !== level && n < limit) begin
      step(name);
      n++;
    end
    if (alarm !== level) begin
      errors++;
      checks++;
      $display("FAIL %s timeout: alarm=%b, expected %b within %0d cycles", name, alarm, level, limit);
    end
  endtask

  load_vec_t vecs[8];

  initial begin
    vecs[0] = '{pk(23, 59, 58), pk(23, 59, 58)};
    vecs[1] = '{pk(24, 0, 0),   pk(23, 59, 58)};
    vecs[2] = '{pk(12, 60, 0),  pk(23, 59, 58)};
    vecs[3] = '{pk(12, 0, 60),  pk(23, 59, 58)};
    vecs[4] = '{pk(31, 63, 63), pk(23, 59, 58)};
    vecs[5] = '{pk(10, 20, 30), pk(10, 20, 30)};
    vecs[6] = '{pk(0, 0, 0),    pk(0, 0, 0)};
    vecs[7] = '{pk(23, 59, 58), pk(23, 59, 58)};

    // Reset holds everything at zero even with run and a valid load requested.
    rst = 1'b0; run = 1'b1; set_time = 1'b1; bin_time = pk(10, 20, 30);
    repeat (3) step("reset");
    chk("reset_time", int'({hour, min, sec}), 0);
    chk("reset_en_day", int'(en_day), 0);
    chk("reset_alarm", int'(alarm), 0);
    set_time = 1'b0;
    rst = 1'b1;
    repeat (3) step("first_tick");
    chk("pre_first_tick_sec", int'(sec), 0);
    step("first_tick");
    chk("first_tick_sec", int'(sec), 1);

    // Valid and invalid loads with time frozen.
    run = 1'b0;
    foreach (vecs[i]) begin
      load(vecs[i].bin);
      chk($sformatf("load_vec%0d", i), int'({hour, min, sec}), int'(vecs[i].exp_time));
    end

    // Midnight rollover and the day pulse.
    run = 1'b1;
    repeat (4) step("rollover");
    chk("rollover_235959", int'({hour, min, sec}), int'(pk(23, 59, 59)));
    repeat (4) step("rollover");
    chk("rollover_000000", int'({hour, min, sec}), 0);
    chk("rollover_en_day", int'(en_day), 1);
    step("rollover");
    chk("rollover_en_day_clear", int'(en_day), 0);

    // Load collides with a tick: load wins, prescaler restarts.
    begin
      int guard = 0;
      while (m_cnt != HZ - 1 && guard < 10) begin
        step("align");
        guard++;
      end
      chk("align_reached", int'(m_cnt == HZ - 1), 1);
    end
    chk("collision_tick_high", int'(tick), 1);
    load(pk(10, 20, 30));
    chk("collision_time", int'({hour, min, sec}), int'(pk(10, 20, 30)));
    chk("collision_en_day", int'(en_day), 0);
    repeat (3) step("collision_after");
    chk("collision_no_early_tick", int'(sec), 30);
    step("collision_after");
    chk("collision_next_tick", int'(sec), 31);
    repeat (3) step("collision_zero_align");
    load(pk(0, 0, 0));
    chk("collision_zero_en_day", int'(en_day), 0);

    // Freeze with run=0, then resume from the held count.
    repeat (2) step("freeze_pre");
    run = 1'b0;
    begin
      logic [16:0] held;
      held = {hour, min, sec};
      repeat (20) step("freeze");
      chk("freeze_time", int'({hour, min, sec}), int'(held));
    end
    run = 1'b1;
    repeat (2) step("resume");
    chk("resume_sec", int'(sec), 1);

    // Alarm behaviour.
    alarm_time = {5'd7, 6'd30};
    alarm_on   = 1'b1;
    load(pk(7, 29, 59));
`ifdef TOD_ALARM_EN
    run_until_alarm(1'b1, 20, "alarm_rise");
    chk("alarm_rise_time", int'({hour, min, sec}), int'(pk(7, 30, 0)));
    alarm_ack = 1'b1;
    step("alarm_ack");
    alarm_ack = 1'b0;
    chk("alarm_ack_clear", int'(alarm), 0);

    load(pk(7, 29, 59));
    run_until_alarm(1'b1, 20, "alarm_rise2");
    run_until_alarm(1'b0, 300, "alarm_timeout");
    chk("alarm_timeout_time", int'({hour, min, sec}), int'(pk(7, 31, 0)));

    load(pk(7, 30, 0));
    chk("alarm_load_no_trigger", int'(alarm), 0);

    load(pk(7, 29, 59));
    run_until_alarm(1'b1, 20, "alarm_rise3");
    alarm_on = 1'b0;
    step("alarm_off");
    chk("alarm_off_clear", int'(alarm), 0);
    alarm_on = 1'b1;

    load(pk(7, 29, 59));
    run_until_alarm(1'b1, 20, "alarm_rise4");
    rst = 1'b0;
    step("alarm_reset");
    rst = 1'b1;
    step("alarm_reset");
    chk("alarm_reset_discard", int'(alarm), 0);
`else
    repeat (8) step("alarm_disabled");
    chk("alarm_disabled_time", int'({hour, min, sec}), int'(pk(7, 30, 1)));
    chk("alarm_disabled", int'(alarm), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
